// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 sequence link: frame FSM states and the default sync pattern.
// Imported by the transmitter and by seq_ctr-style detectors.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_e;

    localparam int                    SYNC_W_DEF = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_DEF   = 4'b1011;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A counter that must hold n-1 needs clog2(n) bits, but never fewer than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_gen_tx_if.sv
// Payload handshake between a frame source and the serial transmitter.
interface seq_gen_tx_if #(
    parameter int DATA_W = 8
);

    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;

    modport master (output load_valid, output load_data, input  load_ready);
    modport slave  (input  load_valid, input  load_data, output load_ready);

endinterface

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter: parallel load, shift left with zero fill, MSB is the serial bit.
module piso_shift #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign dout = q[W-1];

endmodule

// File: rtl/seq_gen_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, then an idle gap of zeros.
// The shifter's MSB is the registered serial line; it drains to zero by the end of DATA.
module seq_gen_tx
    import seq_pkg::*;
#(
    parameter int                SYNC_W  = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC    = SYNC_DEF,
    parameter int                DATA_W  = 8,
    parameter int                GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    seq_gen_tx_if.slave load,
    output logic       opt,
    output logic       opt_en,
    output logic       done
);

    localparam int FRAME_W = SYNC_W + DATA_W;
    localparam int CNT_W   = cnt_width(max3(SYNC_W, DATA_W, GAP_CYC));

    localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);

    seq_state_e         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               ld, sh;
    logic [FRAME_W-1:0] ld_val;
    logic               opt_en_d, done_d;

    piso_shift #(.W(FRAME_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (ld),
        .shift (sh),
        .din   (ld_val),
        .dout  (opt)
    );

    assign load.load_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            opt_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            opt_en <= opt_en_d;
            done   <= done_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ld       = 1'b0;
        sh       = 1'b0;
        ld_val   = '0;
        opt_en_d = 1'b0;
        done_d   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (load.load_valid) begin
                    state_d  = ST_SYNC;
                    cnt_d    = SYNC_LD;
                    ld       = 1'b1;
                    ld_val   = {SYNC, load.load_data};
                    opt_en_d = 1'b1;
                end
            end
            ST_SYNC: begin
                sh       = 1'b1;
                opt_en_d = 1'b1;
                if (cnt == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = DATA_LD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_DATA: begin
                sh = 1'b1;
                if (cnt == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt - 1'b1;
                    opt_en_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                // Unreachable encodings: flush the shifter so opt is 0 once back in IDLE.
                state_d = ST_IDLE;
                cnt_d   = '0;
                ld      = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed bench for seq_gen_tx: reset, framing, back-to-back period, ignored loads,
// mid-frame reset and a loopback 1011 detector.
module tb_seq_gen_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic opt, opt_en, done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t1, t2, pulses;
    logic [11:0] bits;

    seq_gen_tx_if #(.DATA_W(8)) lif ();

    seq_gen_tx dut (
        .clk    (clk),
        .rst    (rst),
        .load   (lif),
        .opt    (opt),
        .opt_en (opt_en),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference seq_ctr-style detector fed by the serial line.
    logic [3:0] hist;
    logic       det;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            det  <= 1'b0;
        end else begin
            hist <= {hist[2:0], opt};
            det  <= ({hist[2:0], opt} == 4'b1011);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_gap();
        @(negedge clk);
        check("gap1_done", done, 1);
        check("gap1_opt", opt, 0);
        check("gap1_en", opt_en, 0);
        check("gap1_ready", lif.load_ready, 0);
        @(negedge clk);
        check("gap2_done", done, 0);
        check("gap2_opt", opt, 0);
        check("gap2_en", opt_en, 0);
        check("gap2_ready", lif.load_ready, 0);
        @(negedge clk);
        check("idle_ready", lif.load_ready, 1);
        check("idle_en", opt_en, 0);
        check("idle_opt", opt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held with load_valid high
        lif.load_valid = 1'b1;
        lif.load_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check("rst_opt", opt, 0);
            check("rst_en", opt_en, 0);
            check("rst_done", done, 0);
            check("rst_ready", lif.load_ready, 1);
        end
        lif.load_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_en", opt_en, 0);
        check("post_rst_ready", lif.load_ready, 1);

        // 2: single A5 frame
        bits = 12'hBA5;
        lif.load_data  = 8'hA5;
        lif.load_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) lif.load_valid = 1'b0;
            check("a5_opt", opt, bits[11-i]);
            check("a5_en", opt_en, 1);
            check("a5_ready", lif.load_ready, 0);
            check("a5_done", done, 0);
        end
        check_gap();

        // 3: back-to-back FF then 00; data changed right after capture
        bits = 12'hBFF;
        lif.load_data  = 8'hFF;
        lif.load_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                t1 = cyc;
                lif.load_data = 8'h00;
            end
            check("ff_opt", opt, bits[11-i]);
            check("ff_en", opt_en, 1);
        end
        repeat (2) begin
            @(negedge clk);
            check("b2b_gap_en", opt_en, 0);
            check("b2b_gap_ready", lif.load_ready, 0);
        end
        @(negedge clk);
        check("b2b_idle_ready", lif.load_ready, 1);
        check("b2b_idle_en", opt_en, 0);
        bits = 12'hB00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                t2 = cyc;
                lif.load_valid = 1'b0;
                check("b2b_period", t2 - t1, 15);
            end
            check("z_opt", opt, bits[11-i]);
            check("z_en", opt_en, 1);
        end
        check_gap();

        // 4: load pulsed with 3C mid-DATA is ignored
        bits = 12'hBA5;
        lif.load_data  = 8'hA5;
        lif.load_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) lif.load_valid = 1'b0;
            check("ign_opt", opt, bits[11-i]);
            check("ign_en", opt_en, 1);
            if (i == 6) begin
                lif.load_valid = 1'b1;
                lif.load_data  = 8'h3C;
            end
            if (i == 7) begin
                lif.load_valid = 1'b0;
                lif.load_data  = 8'hA5;
            end
        end
        check_gap();
        repeat (2) begin
            @(negedge clk);
            check("ign_no_frame", opt_en, 0);
        end

        // 5: reset during DATA bit 3, then a clean 96 frame
        lif.load_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) lif.load_valid = 1'b0;
            check("abort_opt", opt, bits[11-i]);
        end
        rst = 1'b0;
        #1;
        check("abort_opt0", opt, 0);
        check("abort_en0", opt_en, 0);
        check("abort_done0", done, 0);
        check("abort_ready", lif.load_ready, 1);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_en", opt_en, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready", lif.load_ready, 1);
        check("rel_done", done, 0);
        bits = 12'hB96;
        lif.load_data  = 8'h96;
        lif.load_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) lif.load_valid = 1'b0;
            check("clean_opt", opt, bits[11-i]);
            check("clean_en", opt_en, 1);
        end
        check_gap();

        // 6: loopback into a 1011 detector with payload 00
        pulses = 0;
        lif.load_data  = 8'h00;
        lif.load_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 0) lif.load_valid = 1'b0;
            check("det_pulse", det, (i == 4) ? 1 : 0);
            if (det) pulses++;
        end
        check("det_count", pulses, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
